// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side status in, register hold/flush/forward controls out.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] id_rs1addr, id_rs2addr, ex_rs1addr, ex_rs2addr, ex_rdaddr, mem_rdaddr, wb_rdaddr;
  logic id_rs1used, id_rs2used, ex_regwr, ex_br_taken, mem_regwr, mem_memrd, mem_memwr;
  logic dmem_ready, wb_regwr, cnt_clr;
  logic [1:0] ex_wbsel, mem_wbsel;
  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_rs1addr, id_rs2addr, ex_rs1addr, ex_rs2addr, ex_rdaddr, mem_rdaddr, wb_rdaddr,
           id_rs1used, id_rs2used, ex_regwr, ex_br_taken, mem_regwr, mem_memrd, mem_memwr,
           dmem_ready, wb_regwr, cnt_clr, ex_wbsel, mem_wbsel,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush,
           mem_err, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs1addr, id_rs2addr, ex_rs1addr, ex_rs2addr, ex_rdaddr, mem_rdaddr, wb_rdaddr,
           id_rs1used, id_rs2used, ex_regwr, ex_br_taken, mem_regwr, mem_memrd, mem_memwr,
           dmem_ready, wb_regwr, cnt_clr, ex_wbsel, mem_wbsel,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush,
           mem_err, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush, EX forwarding selects and data-memory wait sequencing
// for a 5-stage pipeline.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic acc, last, tmo, mstall, br, lu, mem_ok, wb_ok;
  logic [1:0] mem_fv;
  always_comb begin
    acc    = hz.mem_memrd | hz.mem_memwr;
    last   = state_q == MEM_WAIT && wcnt_q == WW'(MEM_TIMEOUT - 1);
    tmo    = last & !hz.dmem_ready;
    // the abort cycle releases the pipeline; the error is reported one cycle later
    mstall = !rst & acc & !hz.dmem_ready & !tmo;
    br     = !rst & !mstall & hz.ex_br_taken;
    lu     = !rst & !mstall & !br & hz.ex_regwr & hz.ex_wbsel == 2'b01 & |hz.ex_rdaddr &
             ((hz.id_rs1used & hz.id_rs1addr == hz.ex_rdaddr) |
              (hz.id_rs2used & hz.id_rs2addr == hz.ex_rdaddr));
    hz.pc_hold     = mstall | lu;
    hz.ifid_hold   = mstall | lu;
    hz.ifid_flush  = br;
    hz.idex_hold   = mstall;
    hz.idex_flush  = br | lu;
    hz.exmem_hold  = mstall;
    hz.memwb_flush = mstall;
    mem_ok   = hz.mem_regwr & |hz.mem_rdaddr;
    wb_ok    = hz.wb_regwr & |hz.wb_rdaddr;
    mem_fv   = hz.mem_wbsel == 2'b10 ? 2'b11 : 2'b01;
    hz.fwd_a = rst ? 2'b00 : mem_ok && hz.mem_rdaddr == hz.ex_rs1addr ? mem_fv :
               wb_ok && hz.wb_rdaddr == hz.ex_rs1addr ? 2'b10 : 2'b00;
    hz.fwd_b = rst ? 2'b00 : mem_ok && hz.mem_rdaddr == hz.ex_rs2addr ? mem_fv :
               wb_ok && hz.wb_rdaddr == hz.ex_rs2addr ? 2'b10 : 2'b00;
    state_d   = state_q == RUN ? (acc & !hz.dmem_ready ? MEM_WAIT : RUN)
                               : (hz.dmem_ready | last ? RUN : MEM_WAIT);
    wcnt_d    = state_q == MEM_WAIT && state_d == MEM_WAIT ? wcnt_q + 1'b1 : '0;
    mem_err_d = tmo;
    stall_cnt_d = hz.cnt_clr ? '0 : hz.pc_hold & ~&stall_cnt_q ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = hz.cnt_clr ? '0 : br & ~&flush_cnt_q ? flush_cnt_q + 1'b1 : flush_cnt_q;
    hz.mem_err   = mem_err_q;
    hz.stall_cnt = stall_cnt_q;
    hz.flush_cnt = flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam logic [6:0] NO = 7'b0000000, MS = 7'b1101011, LU = 7'b1100100, BR = 7'b0010100;
  typedef struct {
    string nm;
    logic [6:0] ctl;
    logic [1:0] fa, fb;
    logic err, chk;
    logic [CW-1:0] sc, fc;
  } exp_t;
  logic clk = 0, rst = 1;
  exp_t q[$];
  int checks = 0, errors = 0;
  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hz(hz));
  always #5 clk = ~clk;
  task automatic clr();
    {hz.id_rs1addr, hz.id_rs2addr, hz.ex_rs1addr, hz.ex_rs2addr, hz.ex_rdaddr} = '0;
    {hz.mem_rdaddr, hz.wb_rdaddr, hz.ex_wbsel, hz.mem_wbsel} = '0;
    {hz.id_rs1used, hz.id_rs2used, hz.ex_regwr, hz.ex_br_taken, hz.mem_regwr} = '0;
    {hz.mem_memrd, hz.mem_memwr, hz.dmem_ready, hz.wb_regwr, hz.cnt_clr} = '0;
  endtask
  task automatic push(input string nm, input logic [6:0] ctl, input logic [1:0] fa, fb,
                      input logic err, chk, input logic [CW-1:0] sc, fc);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.fa = fa; e.fb = fb; e.err = err; e.chk = chk; e.sc = sc; e.fc = fc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic go(input string nm, input logic [6:0] ctl, input logic [1:0] fa, fb, input logic err);
    push(nm, ctl, fa, fb, err, 1'b0, '0, '0);
  endtask
  task automatic gc(input string nm, input logic [6:0] ctl, input logic [1:0] fa, fb,
                    input logic err, input logic [CW-1:0] sc, fc);
    push(nm, ctl, fa, fb, err, 1'b1, sc, fc);
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      logic [6:0] ctl;
      e = q.pop_front();
      ctl = {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_hold, hz.idex_flush,
             hz.exmem_hold, hz.memwb_flush};
      checks += 4;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s ctl got %b want %b", e.nm, ctl, e.ctl); end
      if (hz.fwd_a !== e.fa) begin errors++; $display("FAIL %s fwd_a got %b want %b", e.nm, hz.fwd_a, e.fa); end
      if (hz.fwd_b !== e.fb) begin errors++; $display("FAIL %s fwd_b got %b want %b", e.nm, hz.fwd_b, e.fb); end
      if (hz.mem_err !== e.err) begin errors++; $display("FAIL %s mem_err got %b want %b", e.nm, hz.mem_err, e.err); end
      if (e.chk) begin
        checks += 2;
        if (hz.stall_cnt !== e.sc) begin errors++; $display("FAIL %s stall_cnt got %0d want %0d", e.nm, hz.stall_cnt, e.sc); end
        if (hz.flush_cnt !== e.fc) begin errors++; $display("FAIL %s flush_cnt got %0d want %0d", e.nm, hz.flush_cnt, e.fc); end
      end
    end
  initial begin
    clr();
    hz.mem_memrd = 1; hz.ex_br_taken = 1; hz.mem_regwr = 1; hz.mem_rdaddr = 3; hz.ex_rs1addr = 3;
    @(posedge clk);
    #1;
    gc("reset", NO, 2'b00, 2'b00, 0, 0, 0);
    rst = 0; clr();
    gc("idle", NO, 2'b00, 2'b00, 0, 0, 0);
    hz.ex_regwr = 1; hz.ex_wbsel = 2'b01; hz.ex_rdaddr = 5;
    hz.id_rs2used = 1; hz.id_rs2addr = 5; hz.id_rs1used = 1; hz.id_rs1addr = 2;
    gc("loaduse", LU, 2'b00, 2'b00, 0, 0, 0);
    hz.ex_regwr = 0;
    gc("loaduse_done", NO, 2'b00, 2'b00, 0, 1, 0);
    clr();
    hz.ex_regwr = 1; hz.ex_wbsel = 2'b01; hz.id_rs1used = 1;
    hz.mem_regwr = 1; hz.wb_regwr = 1;
    gc("x0_nohaz", NO, 2'b00, 2'b00, 0, 1, 0);
    clr();
    hz.ex_rs1addr = 7; hz.ex_rs2addr = 7; hz.mem_regwr = 1; hz.mem_rdaddr = 7; hz.mem_wbsel = 2'b10;
    hz.wb_regwr = 1; hz.wb_rdaddr = 7;
    go("fwd_mem_pcp4", NO, 2'b11, 2'b11, 0);
    hz.mem_regwr = 0;
    go("fwd_wb", NO, 2'b10, 2'b10, 0);
    hz.mem_regwr = 1; hz.mem_wbsel = 2'b00; hz.mem_rdaddr = 9; hz.ex_rs2addr = 9;
    go("fwd_mem_alu", NO, 2'b10, 2'b01, 0);
    clr();
    hz.ex_rs1addr = 7; hz.wb_regwr = 1; hz.wb_rdaddr = 7; hz.mem_memrd = 1;
    for (int i = 0; i < 3; i++) go("memwait", MS, 2'b10, 2'b00, 0);
    hz.dmem_ready = 1;
    gc("mem_release", NO, 2'b10, 2'b00, 0, 4, 0);
    clr();
    gc("after_mem", NO, 2'b00, 2'b00, 0, 4, 0);
    hz.ex_br_taken = 1; hz.ex_regwr = 1; hz.ex_wbsel = 2'b01; hz.ex_rdaddr = 5;
    hz.id_rs1used = 1; hz.id_rs1addr = 5;
    go("branch_over_lu", BR, 2'b00, 2'b00, 0);
    hz.mem_memrd = 1;
    for (int i = 0; i < 2; i++) go("branch_frozen", MS, 2'b00, 2'b00, 0);
    hz.dmem_ready = 1;
    go("branch_release", BR, 2'b00, 2'b00, 0);
    clr();
    gc("after_branch", NO, 2'b00, 2'b00, 0, 6, 2);
    hz.mem_memwr = 1;
    for (int i = 0; i < 4; i++) go("tmo_hold", MS, 2'b00, 2'b00, 0);
    go("tmo_abort", NO, 2'b00, 2'b00, 0);
    clr();
    gc("tmo_err", NO, 2'b00, 2'b00, 1, 10, 2);
    go("tmo_err_done", NO, 2'b00, 2'b00, 0);
    hz.cnt_clr = 1;
    gc("cnt_clr", NO, 2'b00, 2'b00, 0, 10, 2);
    hz.cnt_clr = 0;
    gc("cnt_cleared", NO, 2'b00, 2'b00, 0, 0, 0);
    hz.ex_regwr = 1; hz.ex_wbsel = 2'b01; hz.ex_rdaddr = 4; hz.id_rs2used = 1; hz.id_rs2addr = 4;
    for (int i = 0; i < 17; i++) go("sat_lu", LU, 2'b00, 2'b00, 0);
    clr();
    gc("sat", NO, 2'b00, 2'b00, 0, 15, 0);
    hz.mem_memrd = 1;
    for (int i = 0; i < 3; i++) go("pre_rst_wait", MS, 2'b00, 2'b00, 0);
    rst = 1;
    gc("rst_midwait", NO, 2'b00, 2'b00, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) go("post_rst_wait", MS, 2'b00, 2'b00, 0);
    go("post_rst_abort", NO, 2'b00, 2'b00, 0);
    clr();
    gc("post_rst_err", NO, 2'b00, 2'b00, 1, 4, 0);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
